// File: rtl/opl3_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opl3_seq_pkg
// Purpose  : Shared types and constants for the OPL3 write sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package opl3_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IDX_STB  = 3'd1,
        ST_IDX_WAIT = 3'd2,
        ST_DAT_STB  = 3'd3,
        ST_DAT_WAIT = 3'd4,
        ST_RD_STB   = 3'd5
    } state_t;

    localparam logic ADDR_IDX = 1'b0;
    localparam logic ADDR_DAT = 1'b1;

    typedef struct packed {
        logic       read;
        logic       bank;
        logic [7:0] reg_idx;
        logic [7:0] data;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/opl3_us_delay.sv
`default_nettype none
// ============================================================================
// Module   : opl3_us_delay
// Purpose  : Counts ce_1us ticks from zero up to a target; done is combinational
//            and includes a tick arriving in the current clk.
// Revision : 1.0 - initial release
// ============================================================================
module opl3_us_delay (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce_1us,
    input  logic       start,
    input  logic [7:0] target,
    output logic       done
);

    logic [7:0] r_count;
    logic [8:0] w_count_eff;

    // start is held high while not waiting, so the count is zero on entry
    assign w_count_eff = {1'b0, r_count} + 9'(ce_1us);
    assign done        = (w_count_eff >= {1'b0, target});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= '0;
        end else if (ce_1us && !done) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/opl3_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : opl3_write_sequencer
// Purpose  : OPL3 port initiator: index/data write pairs and status reads with
//            settle delays. Define OPL3_IDX_CACHE_EN to skip repeated index writes.
// Revision : 1.0 - initial release
// ============================================================================
module opl3_write_sequencer
    import opl3_seq_pkg::*;
#(
    parameter int WE_CYCLES    = 2,
    parameter int IDX_DELAY_US = 4,
    parameter int DAT_DELAY_US = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce_1us,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_read,
    input  logic       cmd_bank,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_data,
    output logic [1:0] addr,
    output logic [7:0] din,
    output logic       we,
    output logic       rd,
    input  logic [7:0] dout,
    output logic       status_valid,
    output logic [7:0] status,
    output logic       busy
);

    localparam logic [7:0] c_stb_last  = 8'(WE_CYCLES - 1);
    localparam logic [7:0] c_idx_delay = 8'(IDX_DELAY_US);
    localparam logic [7:0] c_dat_delay = 8'(DAT_DELAY_US);

    state_t     r_state;
    cmd_t       r_cmd;
    logic [7:0] r_stb_cnt;
    logic       w_stb_last;
    logic       w_dly_start;
    logic       w_dly_done;
    logic [7:0] w_dly_target;
    logic       w_idx_hit;
    logic       w_unused_cmd;

    assign cmd_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign w_stb_last   = (r_stb_cnt == c_stb_last);
    assign w_dly_start  = (r_state != ST_IDX_WAIT) && (r_state != ST_DAT_WAIT);
    assign w_dly_target = (r_state == ST_IDX_WAIT) ? c_idx_delay : c_dat_delay;
    // register index is consumed straight from the input at IDLE
    assign w_unused_cmd = ^r_cmd.reg_idx;

    opl3_us_delay u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce_1us (ce_1us),
        .start  (w_dly_start),
        .target (w_dly_target),
        .done   (w_dly_done)
    );

`ifdef OPL3_IDX_CACHE_EN
    logic       r_idx_valid;
    logic [8:0] r_idx_tag;

    assign w_idx_hit = r_idx_valid && (r_idx_tag == {cmd_bank, cmd_reg});

    // a read drives addr[0]=0 on the chip, which clobbers its index latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx_valid <= 1'b0;
            r_idx_tag   <= '0;
        end else if ((r_state == ST_IDLE) && cmd_valid) begin
            if (cmd_read) begin
                r_idx_valid <= 1'b0;
            end else begin
                r_idx_valid <= 1'b1;
                r_idx_tag   <= {cmd_bank, cmd_reg};
            end
        end
    end
`else
    assign w_idx_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cmd        <= '0;
            r_stb_cnt    <= '0;
            addr         <= '0;
            din          <= '0;
            we           <= 1'b0;
            rd           <= 1'b0;
            status       <= '0;
            status_valid <= 1'b0;
        end else begin
            status_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd     <= '{read: cmd_read, bank: cmd_bank,
                                       reg_idx: cmd_reg, data: cmd_data};
                        r_stb_cnt <= '0;
                        if (cmd_read) begin
                            r_state <= ST_RD_STB;
                            addr    <= {cmd_bank, ADDR_IDX};
                            rd      <= 1'b1;
                        end else if (w_idx_hit) begin
                            r_state <= ST_DAT_STB;
                            addr    <= {cmd_bank, ADDR_DAT};
                            din     <= cmd_data;
                            we      <= 1'b1;
                        end else begin
                            r_state <= ST_IDX_STB;
                            addr    <= {cmd_bank, ADDR_IDX};
                            din     <= cmd_reg;
                            we      <= 1'b1;
                        end
                    end
                end
                ST_IDX_STB, ST_RD_STB: begin
                    r_stb_cnt <= r_stb_cnt + 8'd1;
                    if (w_stb_last) begin
                        we <= 1'b0;
                        rd <= 1'b0;
                        if (r_cmd.read) begin
                            status       <= dout;
                            status_valid <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_state <= ST_IDX_WAIT;
                        end
                    end
                end
                ST_IDX_WAIT: begin
                    if (w_dly_done) begin
                        r_state   <= ST_DAT_STB;
                        r_stb_cnt <= '0;
                        addr      <= {r_cmd.bank, ADDR_DAT};
                        din       <= r_cmd.data;
                        we        <= 1'b1;
                    end
                end
                ST_DAT_STB: begin
                    r_stb_cnt <= r_stb_cnt + 8'd1;
                    if (w_stb_last) begin
                        we      <= 1'b0;
                        r_state <= ST_DAT_WAIT;
                    end
                end
                ST_DAT_WAIT: begin
                    if (w_dly_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_opl3_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_opl3_write_sequencer
// Purpose  : Directed bench for opl3_write_sequencer (default delays and a
//            zero-delay instance); expectations follow OPL3_IDX_CACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opl3_write_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       sel = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_read = 1'b0;
    logic       cmd_bank = 1'b0;
    logic [7:0] cmd_reg = 8'h00;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] dout = 8'h00;

    logic       valid_a, ready_a, we_a, rd_a, sv_a, busy_a;
    logic       valid_b, ready_b, we_b, rd_b, sv_b, busy_b;
    logic [1:0] addr_a, addr_b;
    logic [7:0] din_a, din_b, status_a, status_b;

    logic       o_ready, o_we, o_rd, o_sv, o_busy;
    logic [1:0] o_addr;
    logic [7:0] o_din, o_status;

    int vectors = 0;
    int miscompares = 0;
    int ce_cnt = 0;

    int         n_we, n_rd, n_sv, overlap, unstable, acc_ticks, acc_low, tail_ticks, rd_len;
    logic [1:0] p_addr [8];
    logic [7:0] p_din [8];
    int         p_len [8];
    int         p_gapt [8];
    int         p_gapc [8];
    logic [1:0] rd_addr, prev_addr;
    logic [7:0] sv_status, prev_din;
    logic       prev_we, prev_rd;

    logic       c_rd [4];
    logic       c_bk [4];
    logic [7:0] c_rg [4];
    logic [7:0] c_dt [4];

    assign valid_a  = cmd_valid & ~sel;
    assign valid_b  = cmd_valid & sel;
    assign o_ready  = sel ? ready_b  : ready_a;
    assign o_we     = sel ? we_b     : we_a;
    assign o_rd     = sel ? rd_b     : rd_a;
    assign o_sv     = sel ? sv_b     : sv_a;
    assign o_busy   = sel ? busy_b   : busy_a;
    assign o_addr   = sel ? addr_b   : addr_a;
    assign o_din    = sel ? din_b    : din_a;
    assign o_status = sel ? status_b : status_a;

    opl3_write_sequencer #(.WE_CYCLES(2), .IDX_DELAY_US(4), .DAT_DELAY_US(24)) dut (
        .clk(clk), .rst_n(rst_n), .ce_1us(ce), .cmd_valid(valid_a), .cmd_ready(ready_a),
        .cmd_read(cmd_read), .cmd_bank(cmd_bank), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .addr(addr_a), .din(din_a), .we(we_a), .rd(rd_a), .dout(dout),
        .status_valid(sv_a), .status(status_a), .busy(busy_a)
    );

    opl3_write_sequencer #(.WE_CYCLES(2), .IDX_DELAY_US(0), .DAT_DELAY_US(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ce_1us(ce), .cmd_valid(valid_b), .cmd_ready(ready_b),
        .cmd_read(cmd_read), .cmd_bank(cmd_bank), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .addr(addr_b), .din(din_b), .we(we_b), .rd(rd_b), .dout(dout),
        .status_valid(sv_b), .status(status_b), .busy(busy_b)
    );

    initial forever #5 clk = ~clk;

    // one ce_1us pulse every third clk, changing just after the rising edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            ce_cnt = (ce_cnt == 2) ? 0 : ce_cnt + 1;
            ce = (ce_cnt == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input int i);
        cmd_read = c_rd[i];
        cmd_bank = c_bk[i];
        cmd_reg  = c_rg[i];
        cmd_data = c_dt[i];
    endtask

    task automatic set_cmd(input int i, input logic r, input logic b,
                           input logic [7:0] rg, input logic [7:0] dt);
        c_rd[i] = r;
        c_bk[i] = b;
        c_rg[i] = rg;
        c_dt[i] = dt;
    endtask

    task automatic sample();
        if (o_we && o_rd) overlap++;
        if ((o_we && prev_we) || (o_rd && prev_rd))
            if (o_addr != prev_addr || o_din != prev_din) unstable++;
        if (o_we && !prev_we) begin
            p_addr[n_we] = o_addr;
            p_din[n_we]  = o_din;
            p_len[n_we]  = 0;
            p_gapt[n_we] = acc_ticks;
            p_gapc[n_we] = acc_low;
            acc_ticks = 0;
            acc_low   = 0;
            n_we++;
        end
        if (o_we) p_len[n_we-1]++;
        if (o_rd && !prev_rd) begin
            n_rd++;
            rd_addr = o_addr;
            rd_len  = 0;
        end
        if (o_rd) rd_len++;
        if (o_sv) begin
            n_sv++;
            sv_status = o_status;
        end
        if (!o_we && !o_rd && o_busy && ce) acc_ticks++;
        if (!o_we && n_we > 0) acc_low++;
        prev_we   = o_we;
        prev_rd   = o_rd;
        prev_addr = o_addr;
        prev_din  = o_din;
    endtask

    // Issues commands 0..ncmd-1 back to back and samples outputs each clk
    task automatic exec(input int ncmd);
        int idx;
        bit pend;
        bit fin;
        n_we = 0; n_rd = 0; n_sv = 0; overlap = 0; unstable = 0;
        acc_ticks = 0; acc_low = 0; rd_len = 0;
        prev_we = 1'b0; prev_rd = 1'b0; prev_addr = 2'd0; prev_din = 8'd0;
        rd_addr = 2'd0; sv_status = 8'd0;
        for (int i = 0; i < 8; i++) begin
            p_addr[i] = 2'd0; p_din[i] = 8'd0; p_len[i] = 0; p_gapt[i] = 0; p_gapc[i] = 0;
        end
        idx = 0; pend = 1'b0; fin = 1'b0;
        @(negedge clk);
        present(0);
        cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (pend) begin
                idx++;
                pend = 1'b0;
                if (idx < ncmd) present(idx);
                else cmd_valid = 1'b0;
            end
            sample();
            if (cmd_valid && o_ready) pend = 1'b1;
            if (!cmd_valid && !o_busy) fin = 1'b1;
            else @(negedge clk);
        end
        check("exec_completed", int'(fin), 1);
        cmd_valid = 1'b0;
        tail_ticks = acc_ticks;
        check("we_rd_overlap", overlap, 0);
        check("addr_din_stable_in_strobe", unstable, 0);
    endtask

    initial begin
        bit found;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_we", int'(o_we), 0);
        check("rst_rd", int'(o_rd), 0);
        check("rst_addr", int'(o_addr), 0);
        check("rst_din", int'(o_din), 0);
        check("rst_status", int'(o_status), 0);
        check("rst_status_valid", int'(o_sv), 0);
        check("rst_busy", int'(o_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", int'(o_ready), 1);

        // bank0 write 0x20 <- 0x01
        set_cmd(0, 1'b0, 1'b0, 8'h20, 8'h01);
        exec(1);
        check("w1_we_pulses", n_we, 2);
        check("w1_idx_addr", int'(p_addr[0]), 0);
        check("w1_idx_din", int'(p_din[0]), 'h20);
        check("w1_idx_len", p_len[0], 2);
        check("w1_idx_ticks", p_gapt[1], 4);
        check("w1_dat_addr", int'(p_addr[1]), 1);
        check("w1_dat_din", int'(p_din[1]), 'h01);
        check("w1_dat_len", p_len[1], 2);
        check("w1_dat_ticks", tail_ticks, 24);
        check("w1_rd_pulses", n_rd, 0);

        // bank1 write 0x05 <- 0x01
        set_cmd(0, 1'b0, 1'b1, 8'h05, 8'h01);
        exec(1);
        check("w2_we_pulses", n_we, 2);
        check("w2_idx_addr", int'(p_addr[0]), 2);
        check("w2_idx_din", int'(p_din[0]), 'h05);
        check("w2_dat_addr", int'(p_addr[1]), 3);
        check("w2_dat_din", int'(p_din[1]), 'h01);

        // status read
        dout = 8'hE0;
        set_cmd(0, 1'b1, 1'b0, 8'h00, 8'h00);
        exec(1);
        check("rd_pulses", n_rd, 1);
        check("rd_len", rd_len, 2);
        check("rd_addr", int'(rd_addr), 0);
        check("rd_we_pulses", n_we, 0);
        check("rd_status_valid_pulses", n_sv, 1);
        check("rd_status_at_valid", int'(sv_status), 'hE0);
        check("rd_status_after", int'(o_status), 'hE0);
        dout = 8'h00;

        // repeated index (cache applies only when OPL3_IDX_CACHE_EN is set)
        set_cmd(0, 1'b0, 1'b0, 8'hA0, 8'h11);
        exec(1);
        check("c1_we_pulses", n_we, 2);
        set_cmd(0, 1'b0, 1'b0, 8'hA0, 8'h22);
        exec(1);
`ifdef OPL3_IDX_CACHE_EN
        check("c2_we_pulses", n_we, 1);
        check("c2_addr", int'(p_addr[0]), 1);
        check("c2_din", int'(p_din[0]), 'h22);
`else
        check("c2_we_pulses", n_we, 2);
        check("c2_idx_addr", int'(p_addr[0]), 0);
        check("c2_dat_addr", int'(p_addr[1]), 1);
        check("c2_dat_din", int'(p_din[1]), 'h22);
`endif
        set_cmd(0, 1'b0, 1'b0, 8'hB0, 8'h33);
        exec(1);
        check("c3_we_pulses", n_we, 2);
        check("c3_idx_din", int'(p_din[0]), 'hB0);
        check("status_held", int'(o_status), 'hE0);

        // zero-delay instance, two back-to-back writes
        sel = 1'b1;
        set_cmd(0, 1'b0, 1'b0, 8'h40, 8'h3F);
        set_cmd(1, 1'b0, 1'b0, 8'h41, 8'h00);
        exec(2);
        check("z_we_pulses", n_we, 4);
        check("z_gap_idx_dat_1", p_gapc[1], 1);
        check("z_gap_cmd_to_cmd", p_gapc[2], 2);
        check("z_gap_idx_dat_2", p_gapc[3], 1);
        check("z_second_idx_din", int'(p_din[2]), 'h41);
        check("z_last_addr", int'(p_addr[3]), 1);
        check("z_last_len", p_len[3], 2);
        sel = 1'b0;

        // asynchronous reset during the data strobe
        @(negedge clk);
        cmd_read = 1'b0; cmd_bank = 1'b1; cmd_reg = 8'h60; cmd_data = 8'h5A;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 600 && !found; cyc++) begin
            if (o_we && o_addr[0]) found = 1'b1;
            else @(negedge clk);
        end
        check("mid_dat_stb_reached", int'(found), 1);
        rst_n = 1'b0;
        #1;
        check("arst_we", int'(o_we), 0);
        check("arst_busy", int'(o_busy), 0);
        check("arst_addr", int'(o_addr), 0);
        check("arst_status", int'(o_status), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", int'(o_ready), 1);
        check("post_rst_we", int'(o_we), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
